// File: rtl/itcm_ctrl_pkg.sv
// itcm_ctrl_pkg: shared constants and types for the instruction TCM controller.
// Optional parity protection is compiled in by defining ITCM_PARITY_EN.
package itcm_ctrl_pkg;

  localparam int unsigned PC_SIZE    = 32;
  localparam int unsigned INSTR_SIZE = 32;
  localparam int unsigned ITCM_AW    = 10;
  localparam int unsigned ITCM_DEPTH = 1 << ITCM_AW;

  // Byte base of the ITCM window; must be aligned to the window size.
  localparam logic [PC_SIZE-1:0]    ITCM_BASE      = 32'h0000_0000;
  // Word returned in place of data on any access fault.
  localparam logic [INSTR_SIZE-1:0] ITCM_ERR_INSTR = 32'h0000_0000;

  // Lowest PC bit above the word index; bits from here up select the window.
  localparam int unsigned TAG_LSB = ITCM_AW + 2;

  typedef logic [ITCM_AW-1:0]    itcm_addr_t;
  typedef logic [INSTR_SIZE-1:0] itcm_word_t;

  // One response-buffer entry.
  typedef struct packed {
    logic       err;
    itcm_word_t instr;
  } itcm_rsp_t;

  // Even-parity bit: word plus this bit always holds an even number of ones.
  function automatic logic even_parity(input itcm_word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/itcm_rsp_fifo.sv
// itcm_rsp_fifo: 2-entry response buffer with an empty-bypass path, so a word
// pushed into an empty buffer is visible on the output in the same cycle.
module itcm_rsp_fifo
  import itcm_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  itcm_rsp_t push_data_i,
  input  logic      pop_i,
  output logic [1:0] count_o,
  output logic      valid_o,
  output itcm_rsp_t data_o
);

  itcm_rsp_t  entry_q [2];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       bypass;
  logic       do_write;
  logic       do_read;

  // Decide whether this cycle stores and/or retires an entry.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bypass   = push_i & (count_q == 2'd0);
    // A bypassed word consumed in the same cycle never needs storing.
    do_write = push_i & ~(bypass & pop_i);
    do_read  = pop_i & (count_q != 2'd0);
    count_d  = count_q;
    if (do_write && !do_read) begin
      count_d = count_q + 2'd1;
    end else if (!do_write && do_read) begin
      count_d = count_q - 2'd1;
    end
  end

  assign valid_o = (count_q != 2'd0) | bypass;
  assign data_o  = (count_q != 2'd0) ? entry_q[rd_ptr_q] : push_data_i;
  assign count_o = count_q;

  // Storage, pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      count_q <= count_d;
      if (do_write) begin
        entry_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (do_read) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: rtl/itcm_ctrl.sv
// itcm_ctrl: instruction TCM controller. Accepts fetch PCs, reads a single-port
// word array with 1-cycle latency and returns words through a 2-entry buffer.
// A load port preloads program images. Define ITCM_PARITY_EN to store and check
// an even-parity bit per word (adds the ld_par_inv fault-injection input).
module itcm_ctrl
  import itcm_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [PC_SIZE-1:0]    ifu_req_pc,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  output logic                  ifu_rsp_err,
  input  logic                  ld_valid,
  input  logic [ITCM_AW-1:0]    ld_addr,
  input  logic [INSTR_SIZE-1:0] ld_data,
`ifdef ITCM_PARITY_EN
  input  logic                  ld_par_inv,
`endif
  output logic                  itcm_busy
);

  itcm_word_t mem [ITCM_DEPTH];
  itcm_word_t rdata_q;
  logic       inflight_q;
  logic       err_q;

  logic       acc;
  logic       hit;
  itcm_addr_t rd_idx;
  logic [1:0] count;
  logic [2:0] outstanding;
  logic       rd_err;
  itcm_rsp_t  push_data;
  itcm_rsp_t  head;
  logic       rsp_valid;
  logic       pop;

  // Credits: a read in flight plus buffered words never exceed the buffer depth.
  assign outstanding   = {1'b0, count} + {2'b00, inflight_q};
  // Loads own the single array port, so they block new requests.
  assign ifu_req_ready = ~ld_valid & (outstanding < 3'd2);
  assign acc           = ifu_req_valid & ifu_req_ready;

  assign hit    = (ifu_req_pc[1:0] == 2'b00) &
                  (ifu_req_pc[PC_SIZE-1:TAG_LSB] == ITCM_BASE[PC_SIZE-1:TAG_LSB]);
  assign rd_idx = ifu_req_pc[TAG_LSB-1:2];

  // Array write from the load port and synchronous read on acceptance.
  // NOTE: the array and its read register carry no reset; contents survive reset and are defined by loads.
  always_ff @(posedge clk) begin
    if (ld_valid) begin
      mem[ld_addr] <= ld_data;
    end
    if (acc) begin
      rdata_q <= mem[rd_idx];
    end
  end

`ifdef ITCM_PARITY_EN
  logic par_mem [ITCM_DEPTH];
  logic rpar_q;

  // Parity side-array, written and read alongside the data array.
  always_ff @(posedge clk) begin
    if (ld_valid) begin
      par_mem[ld_addr] <= even_parity(ld_data) ^ ld_par_inv;
    end
    if (acc) begin
      rpar_q <= par_mem[rd_idx];
    end
  end

  assign rd_err = err_q | (even_parity(rdata_q) ^ rpar_q);
`else
  assign rd_err = err_q;
`endif

  // Track the single read in flight and whether its address faulted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= acc;
      if (acc) begin
        err_q <= ~hit;
      end
    end
  end

  assign push_data.err   = rd_err;
  assign push_data.instr = rd_err ? ITCM_ERR_INSTR : rdata_q;
  assign pop             = rsp_valid & ifu_rsp_ready;

  itcm_rsp_fifo u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (push_data),
    .pop_i       (pop),
    .count_o     (count),
    .valid_o     (rsp_valid),
    .data_o      (head)
  );

  // Response fields read as zero whenever nothing is presented.
  assign ifu_rsp_valid = rsp_valid;
  assign ifu_rsp_instr = rsp_valid ? head.instr : '0;
  assign ifu_rsp_err   = rsp_valid & head.err;
  assign itcm_busy     = inflight_q | (count != 2'd0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) outstanding <= 3'd2);

endmodule

// File: doc/itcm_ctrl.md
Name: itcm_ctrl

Overview:
- Instruction tightly-coupled memory controller; the direct downstream consumer of the fetch unit's request channel and producer of its response channel.
- Accepts fetch PCs over a valid/ready handshake and reads a single-port word SRAM array with 1-cycle latency.
- Returns instructions through a 2-entry response buffer, so fetch can stream at one word per cycle under back-pressure.
- Also provides a word-write load port, used to preload program images.

Parameters:
PC_SIZE, 32, width of fetch PC
INSTR_SIZE, 32, instruction/data word width
ITCM_AW, 10, word-address width; array depth = 2**ITCM_AW words
ITCM_BASE, 32'h0000_0000, byte base address of the ITCM window (aligned to window size)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  in  1  fetch request valid
ifu_req_ready  out  1  fetch request ready
ifu_req_pc  in  PC_SIZE  fetch byte address
ifu_rsp_valid  out  1  response valid
ifu_rsp_ready  in  1  response ready
ifu_rsp_instr  out  INSTR_SIZE  fetched word
ifu_rsp_err  out  1  access fault for this response
ld_valid  in  1  load-port write strobe
ld_addr  in  ITCM_AW  load word address
ld_data  in  INSTR_SIZE  load word data
itcm_busy  out  1  request in flight or response buffered

Behaviour:
- Reset: clk and reset are one clock domain; reset is asynchronous and active-low. On reset, ifu_rsp_valid=0, ifu_rsp_instr=0, ifu_rsp_err=0, the buffer is empty, inflight=0 and itcm_busy=0. Array contents are not reset.
- Reset asserted mid-operation: in-flight and buffered responses are discarded. No response appears after deassertion unless a new request is made.
- Request acceptance:
  - acc = ifu_req_valid & ifu_req_ready.
  - ifu_req_ready = ~ld_valid & ((count + inflight) < 2), where count is the number of buffered responses (0..2) and inflight is a 1-bit register.
- Address check:
  - hit = (ifu_req_pc[1:0]==0) & (ifu_req_pc[PC_SIZE-1:ITCM_AW+2] == ITCM_BASE[PC_SIZE-1:ITCM_AW+2]).
  - Word index = ifu_req_pc[ITCM_AW+1:2].
- Read timing:
  - On acc, the SRAM read is issued and inflight<=1 with err_q<=~hit.
  - In the next cycle the read data, or 0 if err_q, is pushed into the buffer with err_q.
  - inflight clears unless a new acc occurs in that same cycle.
  - Latency: acc at cycle N -> ifu_rsp_valid=1 at cycle N+1 (the buffer presents its push combinationally through a bypass when empty; the output registers come from the buffer head).
- Response:
  - ifu_rsp_valid = count!=0 or bypass.
  - Pop on ifu_rsp_valid & ifu_rsp_ready.
  - Ordering is strictly FIFO.
  - Throughput is 1/cycle while ifu_rsp_ready=1.
- Simultaneous events:
  - A push and a pop in the same cycle leave count unchanged.
  - Overflow is impossible by construction of ready; the assertion count+inflight<=2 must hold.
- Back-pressure: with ifu_rsp_ready=0, at most 2 requests are accepted; after that ifu_req_ready=0 until a pop occurs.
- Load port:
  - ld_valid writes ld_data to array[ld_addr] at the clock edge.
  - Load has priority: it blocks new requests the same cycle.
  - A read already in flight returns the pre-write value.
- Misaligned PCs and PCs outside the window return instr=0 and err=1; this takes no extra cycles.
- itcm_busy = inflight | (count!=0).

Optional Feature:
- Macro: ITCM_PARITY_EN.
- With the macro defined:
  - Each array word stores an extra even-parity bit computed on load.
  - On read, a parity mismatch forces err=1 and instr=0.
  - Adds input ld_par_inv (1 bit), which inverts the stored parity bit on write for fault injection.
- Without the macro: no parity storage or check, no ld_par_inv port, and err reflects only address faults.

Decomposition:
- Shared defines file:
  - PC_SIZE, INSTR_SIZE, ITCM_AW, ITCM_BASE.
  - ITCM_ERR_INSTR (32'h0).
  - The ITCM_PARITY_EN switch.
- Sub-module itcm_rsp_fifo:
  - 2-entry, {err, instr} wide, with push/pop/count and empty-bypass.
  - Instantiated once.
- The SRAM array is inline behavioural memory in itcm_ctrl.

Test Plan:
- Preload via ld_valid with word0=32'h0000_1093 and word1=32'h0010_0113; request pc=0 at cycle 5 with ifu_rsp_ready=1 -> ifu_rsp_valid=1 at cycle 6 with instr=32'h0000_1093, err=0.
- Back-to-back requests pc=0,4,8 on consecutive cycles with rsp_ready=1 -> three responses on consecutive cycles in order; ifu_req_ready stays 1 throughout.
- Hold ifu_rsp_ready=0 and offer pc=0,4,8 -> two accepted, ifu_req_ready=0 on the third. Raise ready -> responses for 0 and 4 drain, then pc=8 is accepted.
- pc=32'h0000_0002 and pc=ITCM_BASE+(4<<ITCM_AW) -> each responds err=1, instr=0, with 1-cycle latency.
- ld_valid and ifu_req_valid asserted together -> ifu_req_ready=0 that cycle; the request is accepted next cycle and returns the newly written word.
- Assert rst_n=0 with 2 responses buffered -> ifu_rsp_valid=0 immediately, itcm_busy=0. With ITCM_PARITY_EN defined, a load with ld_par_inv=1 followed by a read -> err=1.
